// File: rtl/steer_quad_multi.sv
// Multi-channel steering encoder: left/right levels to Gray quadrature.
// Shared runtime divisor, optional hold-to-accelerate per channel.
module steer_quad_multi #(
  parameter int CHANNELS   = 2,
  parameter int DIV_W      = 16,
  parameter int ACCEL_MAX  = 3,
  parameter int ACCEL_HOLD = 8
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic [DIV_W-1:0]        clkdiv,
  input  logic                    accel_en,
  input  logic [CHANNELS-1:0]     left,
  input  logic [CHANNELS-1:0]     right,
  output logic [2*CHANNELS-1:0]   steer,
  output logic [CHANNELS-1:0]     step,
  output logic [3*CHANNELS-1:0]   level
);

  localparam int HW = $clog2(ACCEL_HOLD + 1);
  localparam logic [2:0] LMAX = 3'(ACCEL_MAX);

  logic [DIV_W-1:0] w_base;
  assign w_base = (clkdiv == '0) ? DIV_W'(1) : clkdiv;

  // dir encoding: bit0 = right, bit1 = left
  function automatic logic [1:0] gstep(
    input logic [1:0] p,
    input logic       dir_r
  );
    logic [1:0] n;
    n = p;
    unique case (p)
      2'b00: n = dir_r ? 2'b01 : 2'b10;
      2'b01: n = dir_r ? 2'b11 : 2'b00;
      2'b11: n = dir_r ? 2'b10 : 2'b01;
      2'b10: n = dir_r ? 2'b00 : 2'b11;
      default: n = p;
    endcase
    return n;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [HW-1:0]    r_hold;
    logic [2:0]       r_lvl;
    logic [1:0]       r_dir;
    logic [1:0]       r_ph;
    logic             r_step;

    logic [DIV_W-1:0] w_shift;
    logic [DIV_W-1:0] w_eff;
    logic [1:0]       w_req;
    logic             w_idle;
    logic             w_rev;
    logic             w_fire;

    assign w_shift = w_base >> r_lvl;
    assign w_eff   = (w_shift == '0) ? DIV_W'(1) : w_shift;
    assign w_req   = {left[i] & ~right[i], right[i] & ~left[i]};
    assign w_idle  = (w_req == 2'b00);
    // a reversal restarts the press; from idle the first cycle counts
    assign w_rev   = !w_idle && (r_dir != 2'b00) && (r_dir != w_req);
    assign w_fire  = !w_idle && !w_rev && (r_cnt >= w_eff - DIV_W'(1));

    always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
        r_cnt  <= '0;
        r_hold <= '0;
        r_lvl  <= '0;
        r_dir  <= '0;
        r_ph   <= '0;
        r_step <= 1'b0;
      end else begin
        r_step <= 1'b0;
        r_dir  <= w_req;
        unique case (1'b1)
          w_idle, w_rev: begin
            r_cnt  <= '0;
            r_hold <= '0;
            r_lvl  <= '0;
          end
          w_fire: begin
            r_cnt  <= '0;
            r_ph   <= gstep(r_ph, w_req[0]);
            r_step <= 1'b1;
            if (r_hold == HW'(ACCEL_HOLD - 1)) begin
              r_hold <= '0;
              r_lvl  <= (r_lvl >= LMAX) ? LMAX : r_lvl + 3'd1;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
          default: r_cnt <= r_cnt + DIV_W'(1);
        endcase
        if (!accel_en) begin
          r_hold <= '0;
          r_lvl  <= '0;
        end
      end
    end

    assign steer[2*i +: 2] = r_ph;
    assign step[i]         = r_step;
    assign level[3*i +: 3] = r_lvl;
  end

endmodule

// File: tb/tb_steer_quad_multi.sv
// Directed bench for steer_quad_multi.
// Two channels, ACCEL_MAX=2, ACCEL_HOLD=2.
module tb_steer_quad_multi;

  logic        CLK;
  logic        Reset_n;
  logic [15:0] clkdiv;
  logic        accel_en;
  logic [1:0]  left;
  logic [1:0]  right;
  logic [3:0]  steer;
  logic [1:0]  step;
  logic [5:0]  level;

  int n_chk;
  int n_fail;
  logic [1:0] ph0;
  logic [1:0] ph1;

  steer_quad_multi #(
    .CHANNELS(2),
    .DIV_W(16),
    .ACCEL_MAX(2),
    .ACCEL_HOLD(2)
  ) dut (
    .CLK(CLK),
    .Reset_n(Reset_n),
    .clkdiv(clkdiv),
    .accel_en(accel_en),
    .left(left),
    .right(right),
    .steer(steer),
    .step(step),
    .level(level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [1:0] nr(input logic [1:0] p);
    case (p)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nl(input logic [1:0] p);
    case (p)
      2'b00: return 2'b10;
      2'b10: return 2'b11;
      2'b11: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; clkdiv = 16'd4; accel_en = 1'b0;
    left = 2'b00; right = 2'b00;
    #1 Reset_n = 1'b0;
    #1;
    n_chk++;
    if ({steer, step, level} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_init: got %h want 000", {steer, step, level});
    end
    tick(); tick();
    Reset_n = 1'b1;
    tick();
    n_chk++;
    if ({steer, step, level} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_release: got %h want 000", {steer, step, level});
    end
    right = 2'b01;
    repeat (8) tick();
    n_chk++;
    if (steer[1:0] !== 2'b11 || step[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: got steer %b step %b want 11 1", steer[1:0], step[0]);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_chk++;
    if ({steer, step, level} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 000", {steer, step, level});
    end
    right = 2'b00;
    tick();
    Reset_n = 1'b1;
    tick(); tick();
    n_chk++;
    if ({steer, step, level} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_after: got %h want 000", {steer, step, level});
    end
    ph0 = 2'b00; ph1 = 2'b00;
  endtask

  task automatic test_fixed_rate();
    logic es;
    clkdiv = 16'd4; accel_en = 1'b0; right = 2'b01; left = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      tick();
      es = (k % 4 == 0);
      if (es) ph0 = nr(ph0);
      n_chk++;
      if (step !== {1'b0, es} || steer !== {ph1, ph0} || level !== 6'd0) begin
        n_fail++;
        $display("FAIL fixed k=%0d: got step %b steer %b lvl %h want %b %b 00",
                 k, step, steer, level, {1'b0, es}, {ph1, ph0});
      end
    end
    right = 2'b00;
    tick();
  endtask

  task automatic test_accel();
    logic es;
    logic [2:0] el;
    clkdiv = 16'd8; accel_en = 1'b1; left = 2'b10; right = 2'b00;
    for (int k = 1; k <= 32; k++) begin
      tick();
      es = (k inside {8, 16, 20, 24, 26, 28, 30, 32});
      el = (k < 16) ? 3'd0 : (k < 24) ? 3'd1 : 3'd2;
      if (es) ph1 = nl(ph1);
      n_chk++;
      if (step !== {es, 1'b0} || level !== {el, 3'd0} || steer !== {ph1, ph0}) begin
        n_fail++;
        $display("FAIL accel k=%0d: got step %b lvl %h steer %b want %b %h %b",
                 k, step, level, steer, {es, 1'b0}, {el, 3'd0}, {ph1, ph0});
      end
    end
    left = 2'b00;
    tick();
    n_chk++;
    if (level !== 6'd0 || step !== 2'b00) begin
      n_fail++;
      $display("FAIL accel_release: got lvl %h step %b want 00 00", level, step);
    end
    left = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      es = (k == 8);
      if (es) ph1 = nl(ph1);
      n_chk++;
      if (step !== {es, 1'b0} || steer !== {ph1, ph0}) begin
        n_fail++;
        $display("FAIL accel_repress k=%0d: got step %b steer %b want %b %b",
                 k, step, steer, {es, 1'b0}, {ph1, ph0});
      end
    end
    left = 2'b00; accel_en = 1'b0;
    tick();
  endtask

  task automatic test_conflict_reversal();
    logic es;
    clkdiv = 16'd4; left = 2'b01; right = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++;
      if (step !== 2'b00 || steer !== {ph1, ph0}) begin
        n_fail++;
        $display("FAIL conflict k=%0d: got step %b steer %b want 00 %b",
                 k, step, steer, {ph1, ph0});
      end
    end
    left = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      es = (k % 4 == 0);
      if (es) ph0 = nr(ph0);
      n_chk++;
      if (step !== {1'b0, es} || steer !== {ph1, ph0}) begin
        n_fail++;
        $display("FAIL rev_run k=%0d: got step %b steer %b want %b %b",
                 k, step, steer, {1'b0, es}, {ph1, ph0});
      end
    end
    left = 2'b01; right = 2'b00;
    tick();
    n_chk++;
    if (step !== 2'b00 || steer[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL rev_switch: got step %b steer %b want 00 11", step, steer[1:0]);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      es = (k == 4);
      if (es) ph0 = nl(ph0);
      n_chk++;
      if (step !== {1'b0, es} || steer !== {ph1, ph0}) begin
        n_fail++;
        $display("FAIL rev_after k=%0d: got step %b steer %b want %b %b",
                 k, step, steer, {1'b0, es}, {ph1, ph0});
      end
    end
    left = 2'b00;
    tick();
  endtask

  task automatic test_divisor_edges();
    int spurious;
    logic es;
    for (int d = 0; d <= 1; d++) begin
      clkdiv = 16'(d); right = 2'b01;
      for (int k = 1; k <= 4; k++) begin
        tick();
        ph0 = nr(ph0);
        n_chk++;
        if (step !== 2'b01 || steer !== {ph1, ph0}) begin
          n_fail++;
          $display("FAIL div%0d k=%0d: got step %b steer %b want 01 %b",
                   d, k, step, steer, {ph1, ph0});
        end
      end
    end
    right = 2'b00;
    tick();
    clkdiv = 16'd100; right = 2'b01;
    spurious = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (step !== 2'b00) spurious++;
    end
    n_chk++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL div100_quiet: got %0d steps want 0", spurious);
    end
    clkdiv = 16'd4;
    tick();
    ph0 = nr(ph0);
    n_chk++;
    if (step !== 2'b01 || steer !== {ph1, ph0}) begin
      n_fail++;
      $display("FAIL div_drop: got step %b steer %b want 01 %b", step, steer, {ph1, ph0});
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      es = (k == 4);
      if (es) ph0 = nr(ph0);
      n_chk++;
      if (step !== {1'b0, es} || steer !== {ph1, ph0}) begin
        n_fail++;
        $display("FAIL div_after k=%0d: got step %b steer %b want %b %b",
                 k, step, steer, {1'b0, es}, {ph1, ph0});
      end
    end
    right = 2'b00;
    tick();
  endtask

  task automatic test_independence();
    logic es;
    clkdiv = 16'd6; right = 2'b01; left = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      tick();
      es = (k % 6 == 0);
      if (es) begin
        ph0 = nr(ph0);
        ph1 = nl(ph1);
      end
      n_chk++;
      if (step !== {es, es} || steer !== {ph1, ph0} || level !== 6'd0) begin
        n_fail++;
        $display("FAIL indep k=%0d: got step %b steer %b lvl %h want %b %b 00",
                 k, step, steer, level, {es, es}, {ph1, ph0});
      end
    end
    right = 2'b00; left = 2'b00;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_fixed_rate();
    test_accel();
    test_conflict_reversal();
    test_divisor_edges();
    test_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/steer_quad_multi.md
Name: steer_quad_multi

Overview:
- Multi-channel digital-to-quadrature steering encoder; successor to the single-channel joy2quad.
- Converts per-player left/right button levels into 2-bit Gray-code quadrature (SteerA/SteerB) for the game core's steering inputs.
- Adds N channels, a shared runtime rate divisor, and optional hold-to-accelerate.
- Sits between hps_io joystick decode and the game core; all logic runs in the video clock domain.

Parameters:
- CHANNELS, 2, number of independent steering channels (1..4).
- DIV_W, 16, width of the clkdiv rate input.
- ACCEL_MAX, 3, maximum acceleration level (1..7); the divisor is right-shifted by the level.
- ACCEL_HOLD, 8, number of steps emitted at one level before the level increments (>=1).

Ports:
- CLK, in, 1: sole clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- clkdiv, in, DIV_W: base step period in CLK cycles; value 0 is treated as 1.
- accel_en, in, 1: 1 enables acceleration; 0 gives a fixed rate.
- left, in, CHANNELS: per-channel left request, active-high, synchronous to CLK.
- right, in, CHANNELS: per-channel right request, active-high.
- steer, out, 2*CHANNELS: channel i drives A on bit 2i+1 and B on bit 2i.
- step, out, CHANNELS: one-cycle pulse in the same cycle steer changes.
- level, out, 3*CHANNELS: current acceleration level of channel i on bits 3i+2:3i.

Behaviour:
- Reset (async assert): steer=0, step=0, level=0; internal period counter, hold counter and direction register all cleared. Outputs go to 0 immediately. Deassertion takes effect on the next CLK edge.
- Channels are fully independent and identical; only clkdiv and accel_en are shared.
- Per-channel request decode:
  - IDLE when left==right (neither or both pressed).
  - RIGHT when only right is pressed.
  - LEFT when only left is pressed.
- IDLE:
  - Period counter=0, hold=0, level=0.
  - steer holds its value; step=0.
- Effective period: eff = max(1, max(clkdiv,1) >> level), computed combinationally each cycle.
- Active (RIGHT or LEFT), direction unchanged from the previous cycle:
  - Period counter increments each cycle.
  - When counter >= eff-1: counter<=0, phase advances one Gray step, step<=1.
  - Using >= makes a mid-run clkdiv decrease (or level increase) fire on the next cycle, never wrap.
- Latency:
  - First edge is registered at the end of the eff-th active cycle, i.e. visible eff cycles after the first active sample.
  - The step pulse coincides with the steer change.
- Gray sequence, AB notation:
  - RIGHT advances 00->01->11->10->00.
  - LEFT advances 00->10->11->01->00.
  - Wraps indefinitely.
- Direction reversal (RIGHT<->LEFT with no IDLE cycle between):
  - Treated as a fresh press: counter, hold and level cleared; no step that cycle.
  - steer keeps its phase, so the next edge moves the opposite way from the current phase.
- Acceleration, accel_en=1:
  - Each step increments hold.
  - When hold reaches ACCEL_HOLD: hold<=0, level<=min(level+1, ACCEL_MAX).
  - Level is saturating.
- accel_en=0: level and hold are forced to 0 every cycle. Dropping accel_en mid-run resets the level the next cycle without disturbing the phase.
- No combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: assert Reset_n=0 mid-run with steer=11 -> steer, step and level read 0 with no clock edge; after release plus 1 cycle with no request, outputs stay 0.
- Fixed rate (CHANNELS=2, clkdiv=4, accel_en=0), hold right[0] -> steer[1:0] = 01, 11, 10, 00 at cycles 4, 8, 12, 16. step[0] pulses on exactly those cycles. steer[3:2]=00 and level=0 throughout.
- Acceleration (ACCEL_MAX=2, ACCEL_HOLD=2, clkdiv=8, accel_en=1), hold left[1] -> step intervals 8,8,4,4,2,2,2,... and level[5:3] goes 0->1->2, then saturates. Releasing for 1 cycle returns level to 0, and the next press yields an 8-cycle first interval.
- Conflict/reversal: with left[0]=right[0]=1, steer[1:0] is frozen and step=0. Holding right to phase 11, then switching directly to left -> no step that cycle; 01 appears 4 cycles later (clkdiv=4).
- Divisor edges: clkdiv=0 and clkdiv=1 with right held -> step every cycle. clkdiv dropped from 100 to 4 while the counter is at 50 -> step on the next cycle, then every 4 cycles.
- Channel independence: right[0] at clkdiv=6 with left[1] held simultaneously -> both channels step every 6 cycles in opposite Gray directions, with step[1:0]=11 on the same cycles.
